// File: rtl/i2s_target.sv
// i2s_target: I2S bus target, 24-bit slots, receives and transmits a stereo pair per frame
module i2s_target #(
  parameter int DataWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 sclk_i,
  input  logic                 lrck_i,
  input  logic                 sd_in_i,
  output logic                 sd_out_o,
  output logic [DataWidth-1:0] rx_left_o,
  output logic [DataWidth-1:0] rx_right_o,
  output logic                 rx_valid_o,
  input  logic [DataWidth-1:0] tx_left_i,
  input  logic [DataWidth-1:0] tx_right_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_underrun_o,
  output logic                 framing_error_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_e;
  localparam logic [4:0] DW5 = 5'(DataWidth);
  state_e               state_q;
  logic [2:0]           sclk_q;
  logic [1:0]           lrck_q, sd_q;
  logic                 lrck_prev_q, left_ok_q, stg_full_q;
  logic [4:0]           bit_cnt_q;
  logic [DataWidth-1:0] rx_sh_q, rx_sh_d, left_q;
  logic [DataWidth-1:0] stg_l_q, stg_r_q, tx_r_q, out_sh_q;
  logic                 rise, fall, change, frame_start, capture, last;
  assign rise        = sclk_q[1] & ~sclk_q[2];
  assign fall        = ~sclk_q[1] & sclk_q[2];
  assign change      = rise & (lrck_q[1] != lrck_prev_q);
  assign frame_start = change & lrck_prev_q;
  assign capture     = rise & ~change & (state_q == SHIFT);
  assign last        = capture & (bit_cnt_q == 5'd23);
  // only the first DataWidth slot bits shift in; the rest are truncated
  assign rx_sh_d     = (bit_cnt_q < DW5) ? {rx_sh_q[DataWidth-2:0], sd_q[1]} : rx_sh_q;
  assign tx_ready_o  = ~stg_full_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      sclk_q          <= '0;
      lrck_q          <= '0;
      sd_q            <= '0;
      lrck_prev_q     <= 1'b0;
      left_ok_q       <= 1'b0;
      stg_full_q      <= 1'b0;
      bit_cnt_q       <= '0;
      rx_sh_q         <= '0;
      left_q          <= '0;
      stg_l_q         <= '0;
      stg_r_q         <= '0;
      tx_r_q          <= '0;
      out_sh_q        <= '0;
      sd_out_o        <= 1'b0;
      rx_left_o       <= '0;
      rx_right_o      <= '0;
      rx_valid_o      <= 1'b0;
      tx_underrun_o   <= 1'b0;
      framing_error_o <= 1'b0;
    end else begin
      sclk_q          <= {sclk_q[1:0], sclk_i};
      lrck_q          <= {lrck_q[0], lrck_i};
      sd_q            <= {sd_q[0], sd_in_i};
      rx_valid_o      <= 1'b0;
      tx_underrun_o   <= 1'b0;
      framing_error_o <= 1'b0;
      if (rise) lrck_prev_q <= lrck_q[1];
      if (change) begin
        framing_error_o <= state_q == SHIFT;
        state_q         <= SHIFT;
        bit_cnt_q       <= '0;
        if (!lrck_q[1]) left_ok_q <= 1'b0;
      end else if (capture) begin
        bit_cnt_q <= bit_cnt_q + 5'd1;
        rx_sh_q   <= rx_sh_d;
        if (last) begin
          state_q <= HOLD;
          if (!lrck_prev_q) begin
            left_q    <= rx_sh_d;
            left_ok_q <= 1'b1;
          end else if (left_ok_q) begin
            rx_left_o  <= left_q;
            rx_right_o <= rx_sh_d;
            rx_valid_o <= 1'b1;
          end
        end
      end
      // a left-slot start takes the staged pair; the right half waits in tx_r_q
      if (frame_start) begin
        stg_full_q    <= 1'b0;
        tx_underrun_o <= ~stg_full_q;
        out_sh_q      <= stg_full_q ? stg_l_q : '0;
        tx_r_q        <= stg_full_q ? stg_r_q : '0;
      end else begin
        if (change) out_sh_q <= tx_r_q;
        else if (fall) begin
          sd_out_o <= out_sh_q[DataWidth-1];
          out_sh_q <= out_sh_q << 1;
        end
        if (tx_valid_i && !stg_full_q) begin
          stg_l_q    <= tx_left_i;
          stg_r_q    <= tx_right_i;
          stg_full_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_target.sv
// tb_i2s_target: bench acting as I2S master with a frame-level reference model
module tb_i2s_target;
  localparam int DW = 12;
  logic clk = 1'b0, reset, sclk, lrck, sd;
  logic sd_out, rx_valid, tx_valid, tx_ready, tx_underrun, framing_error;
  logic [DW-1:0] rx_left, rx_right, tx_left, tx_right;
  logic [DW-1:0] exp_l, exp_r;
  int n_chk = 0, n_fail = 0;
  int n_valid = 0, n_under = 0, n_ferr = 0, n_xfer = 0, n_rdy_low = 0;
  i2s_target #(.DataWidth(DW)) dut (
    .clk_i(clk), .reset_i(reset), .sclk_i(sclk), .lrck_i(lrck), .sd_in_i(sd),
    .sd_out_o(sd_out), .rx_left_o(rx_left), .rx_right_o(rx_right), .rx_valid_o(rx_valid),
    .tx_left_i(tx_left), .tx_right_i(tx_right), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .tx_underrun_o(tx_underrun), .framing_error_o(framing_error));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid) n_valid <= n_valid + 1;
    if (tx_underrun) n_under <= n_under + 1;
    if (framing_error) n_ferr <= n_ferr + 1;
    if (tx_valid && tx_ready) n_xfer <= n_xfer + 1;
    if (!tx_ready) n_rdy_low <= n_rdy_low + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic load(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int i = 0;
    @(posedge clk) #1;
    tx_left = l;
    tx_right = r;
    tx_valid = 1'b1;
    while (!tx_ready && i < 100) begin
      @(posedge clk) #1;
      i++;
    end
    check("load_ready", {31'd0, tx_ready}, 1);
    @(posedge clk) #1;
    tx_valid = 1'b0;
    check("ready_after_load", {31'd0, tx_ready}, 0);
  endtask
  // one channel slot of n sclk periods; position 0 carries the lrck change
  task automatic slot(input logic ch, input logic [23:0] w, input int n, input int rst_pos,
                      output logic [23:0] cap);
    cap = '0;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      sclk = 1'b0;
      if (k == 0) lrck = ch;
      sd = (k >= 1 && k <= 24) ? w[24-k] : 1'($urandom);
      if (k == rst_pos) begin
        #20 reset = 1'b1;
        #1;
        check("rst_sd_out", {31'd0, sd_out}, 0);
        check("rst_rx_left", 32'(rx_left), 0);
        check("rst_rx_right", 32'(rx_right), 0);
        check("rst_tx_ready", {31'd0, tx_ready}, 1);
        #29 reset = 1'b0;
        #30;
        return;
      end
      #80;
      if (k >= 1 && k <= 24) cap[24-k] = sd_out;
      sclk = 1'b1;
      #80;
    end
  endtask
  task automatic frame(input logic [23:0] l, input logic [23:0] r, input bit ld, input bit stg,
                       input logic [DW-1:0] txl, input logic [DW-1:0] txr);
    logic [23:0] cl, cr;
    int v0, u0, f0;
    if (ld) load(txl, txr);
    v0 = n_valid;
    u0 = n_under;
    f0 = n_ferr;
    slot(1'b0, l, 32, -1, cl);
    slot(1'b1, r, 32, -1, cr);
    @(negedge clk);
    exp_l = l[23:24-DW];
    exp_r = r[23:24-DW];
    check("rx_valid_cnt", n_valid - v0, 1);
    check("rx_left", 32'(rx_left), 32'(exp_l));
    check("rx_right", 32'(rx_right), 32'(exp_r));
    check("tx_cap_l", 32'(cl), stg ? 32'(txl) << (24 - DW) : 0);
    check("tx_cap_r", 32'(cr), stg ? 32'(txr) << (24 - DW) : 0);
    check("underrun_cnt", u0 > n_under ? 0 : n_under - u0, stg ? 0 : 1);
    check("ferr_cnt", n_ferr - f0, 0);
  endtask
  initial begin
    logic [23:0] cap;
    int v0, u0, f0, x0;
    bit ld;
    logic [DW-1:0] tl, tr;
    reset = 1'b1;
    sclk = 1'b1;
    lrck = 1'b0;
    sd = 1'b0;
    tx_valid = 1'b0;
    tx_left = '0;
    tx_right = '0;
    repeat (3) @(negedge clk);
    check("reset_sd_out", {31'd0, sd_out}, 0);
    check("reset_rx_left", 32'(rx_left), 0);
    check("reset_rx_right", 32'(rx_right), 0);
    check("reset_rx_valid", {31'd0, rx_valid}, 0);
    check("reset_tx_ready", {31'd0, tx_ready}, 1);
    check("reset_underrun", {31'd0, tx_underrun}, 0);
    check("reset_ferr", {31'd0, framing_error}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    load(12'h800, 12'h7FF);
    v0 = n_valid;
    slot(1'b1, 24'($urandom), 32, -1, cap);
    check("lone_right_sd_out", 32'(cap), 0);
    check("lone_right_valid", n_valid - v0, 0);
    frame(24'hABC000, 24'h123000, 1'b0, 1'b1, 12'h800, 12'h7FF);
    for (int i = 0; i < 6; i++) begin
      ld = 1'($urandom);
      frame(24'($urandom), 24'($urandom), ld, ld, DW'($urandom), DW'($urandom));
    end
    x0 = n_rdy_low;
    frame(24'($urandom), 24'($urandom), 1'b0, 1'b0, '0, '0);
    frame(24'($urandom), 24'($urandom), 1'b0, 1'b0, '0, '0);
    check("idle_ready_low_cycles", n_rdy_low - x0, 0);
    v0 = n_valid;
    u0 = n_under;
    f0 = n_ferr;
    slot(1'b0, 24'($urandom), 11, -1, cap);
    slot(1'b1, 24'($urandom), 32, -1, cap);
    @(negedge clk);
    check("short_ferr_cnt", n_ferr - f0, 1);
    check("short_valid_cnt", n_valid - v0, 0);
    check("short_underrun_cnt", n_under - u0, 1);
    check("short_rx_left_kept", 32'(rx_left), 32'(exp_l));
    check("short_rx_right_kept", 32'(rx_right), 32'(exp_r));
    frame(24'($urandom), 24'($urandom), 1'b1, 1'b1, DW'($urandom), DW'($urandom));
    slot(1'b0, 24'($urandom), 32, -1, cap);
    slot(1'b1, 24'($urandom), 32, 12, cap);
    v0 = n_valid;
    u0 = n_under;
    f0 = n_ferr;
    slot(1'b0, 24'($urandom), 32, -1, cap);
    check("post_rst_left_sd_out", 32'(cap), 0);
    slot(1'b1, 24'($urandom), 32, -1, cap);
    check("post_rst_right_sd_out", 32'(cap), 0);
    @(negedge clk);
    check("post_rst_valid_cnt", n_valid - v0, 0);
    check("post_rst_underrun_cnt", n_under - u0, 0);
    check("post_rst_ferr_cnt", n_ferr - f0, 0);
    frame(24'($urandom), 24'($urandom), 1'b1, 1'b1, DW'($urandom), DW'($urandom));
    tl = DW'($urandom);
    tr = DW'($urandom);
    @(posedge clk) #1;
    x0 = n_xfer;
    tx_left = tl;
    tx_right = tr;
    tx_valid = 1'b1;
    frame(24'($urandom), 24'($urandom), 1'b0, 1'b1, tl, tr);
    frame(24'($urandom), 24'($urandom), 1'b0, 1'b1, tl, tr);
    @(posedge clk) #1;
    tx_valid = 1'b0;
    check("held_valid_xfer_cnt", n_xfer - x0, 3);
    check("held_valid_ready_end", {31'd0, tx_ready}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/i2s_target.md
I2S_TARGET -- requirements
Module: i2s_target

Interface
REQ-001 Parameter DataWidth, default 12, SHALL set the sample width of each channel at the parallel ports (legal range 2..24).
REQ-002 The slot width SHALL be a fixed 24 bits per channel, 64 sclk per frame; this is not a parameter.
REQ-003 clk  input  1  system clock; the block SHALL use one clock only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sclk  input  1  external I2S bit clock from the bus master; asynchronous to clk.
REQ-006 lrck  input  1  external word select; 0 = left channel, 1 = right channel.
REQ-007 sdIn  input  1  serial data from the master.
REQ-008 sdOut  output  1  serial data to the master.
REQ-009 rxLeft, rxRight  output  DataWidth each  last received stereo sample pair, two's complement.
REQ-010 rxValid  output  1  one-clk pulse; rxLeft/rxRight updated this cycle.
REQ-011 txLeft, txRight  input  DataWidth each  sample pair to transmit.
REQ-012 txValid  input  1  txLeft/txRight valid.
REQ-013 txReady  output  1  staging register empty; transfer occurs on txValid && txReady.
REQ-014 txUnderrun  output  1  one-clk pulse; a frame started with staging empty.
REQ-015 framingError  output  1  one-clk pulse; a channel slot ended before 24 bits were received.

Function
REQ-016 sclk, lrck and sdIn SHALL each pass through a 2-flop synchronizer; one further flop on synchronized sclk SHALL provide edge detection (rise strobe, fall strobe).
REQ-017 Correct operation SHALL require F_clk >= 8 x F_sclk; behaviour below this ratio is undefined.
REQ-018 On each rise strobe: lrck and sdIn SHALL be sampled, and the sampled lrck SHALL be compared with the value sampled at the previous rise.
REQ-019 An lrck change at a rise SHALL start a new slot: bitCount := 0 and the sdIn bit at that rise SHALL be discarded (I2S one-bit delay).
REQ-020 Receive states: IDLE (wait for the first lrck change), SHIFT (bitCount 1..24 captured MSB first), HOLD (bits after 24 ignored until the next lrck change).
REQ-021 IDLE->SHIFT on any lrck change; SHIFT->HOLD after the 24th bit; HOLD->SHIFT on an lrck change; SHIFT->SHIFT with restart on an lrck change before bit 24.
REQ-022 Only slot bits 23 down to 24-DataWidth SHALL be kept; the remaining LSBs SHALL be dropped without rounding.
REQ-023 The left capture SHALL be held internally; on completion of the 24th right-channel bit, rxLeft/rxRight SHALL both update and rxValid SHALL pulse in the next clk cycle.
REQ-024 A right slot that follows an incomplete left slot SHALL still be received, but no rxValid SHALL be generated for that frame.
REQ-025 An lrck change while in SHIFT with bitCount < 24 SHALL pulse framingError, discard the partial slot and restart per REQ-019; rxLeft/rxRight SHALL keep their old values.
REQ-026 Transmit: txReady SHALL be 1 while staging is empty; txValid && txReady SHALL load staging and drop txReady in the next cycle.
REQ-027 At an lrck change 1->0 (start of a left slot), staging SHALL move to the tx shift register and txReady SHALL rise; if staging is empty, zeros SHALL be loaded and txUnderrun SHALL pulse.
REQ-028 On each fall strobe after a slot start, sdOut SHALL present slot bits MSB first: sample bits for positions 1..DataWidth, then 0 through the end of the slot.
REQ-029 sdOut SHALL change only on fall strobes; after the right slot, sdOut SHALL be 0.
REQ-030 In IDLE, sdOut SHALL be 0.
REQ-031 A simultaneous txValid and frame-start transfer SHALL give priority to the frame start; the new data SHALL load staging in the following cycle if txValid remains asserted.

Reset
REQ-032 Asserting reset SHALL immediately clear all state: synchronizers 0, state IDLE, bitCount 0, staging empty.
REQ-033 Output reset values SHALL be: sdOut 0, rxLeft 0, rxRight 0, rxValid 0, txReady 1, txUnderrun 0, framingError 0.
REQ-034 Reset asserted mid-frame SHALL discard all partial data; after release, no rxValid SHALL occur before one full left+right frame following the first lrck change.

Verification
REQ-035 sclk = clk/16, master sends L = 0xABC000, R = 0x123000, DataWidth = 12 -> rxLeft = 0xABC, rxRight = 0x123, exactly one rxValid per frame.
REQ-036 txLeft = 0x800, txRight = 0x7FF loaded before a frame -> the master captures L = 0x800000, R = 0x7FF000; txUnderrun stays 0.
REQ-037 No txValid across two frames -> sdOut = 0 for both frames; txUnderrun pulses once per frame; txReady stays 1.
REQ-038 lrck toggles after 10 left bits -> framingError pulses once; no rxValid for that frame; the next complete frame yields correct rxValid.
REQ-039 Reset pulsed during bit 12 of the right slot -> all outputs take reset values asynchronously; the first rxValid arrives only after a full subsequent frame.
REQ-040 txValid held high continuously -> exactly one transfer per frame; txReady rises in the cycle after each left-slot start.
